// File: rtl/triangular_root.sv
// triangular_root: multi-cycle FSMD that finds the largest N with 1+2+..+N <= target.
// It subtracts 1, 2, 3, ... from the target until the next step no longer fits.
// It reports N, the leftover remainder, and whether the target is exactly triangular.
// Optional build macro TRIROOT_FAST_EN merges SUB and INC into one state.
// This gives 2-cycle iterations instead of 3-cycle iterations.
module triangular_root #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] n,
    output logic [WIDTH-1:0] rem,
    output logic             exact,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        SUB  = 3'd2,
        INC  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] i;

    // State register; reset discards any in-flight computation.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic. start is only honoured in IDLE and DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CMP;
            CMP:     state_nxt = (rem >= i) ? SUB : DONE;
`ifdef TRIROOT_FAST_EN
            SUB:     state_nxt = CMP;
`else
            SUB:     state_nxt = INC;
`endif
            INC:     state_nxt = CMP;
            DONE:    if (start) state_nxt = CMP;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath. The CMP guard ensures rem never underflows.
    // i stays at or below N+1, which fits in WIDTH bits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            n   <= '0;
            rem <= '0;
            i   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        rem <= target;
                        i   <= WIDTH'(1);
                        n   <= '0;
                    end
                end
                SUB: begin
                    rem <= rem - i;
                    n   <= i;
`ifdef TRIROOT_FAST_EN
                    i   <= i + WIDTH'(1);
`endif
                end
                INC:     i <= i + WIDTH'(1);
                default: ;
            endcase
        end
    end

    assign busy  = (state == CMP) || (state == SUB) || (state == INC);
    assign done  = (state == DONE);
    assign exact = (state == DONE) && (rem == '0);

endmodule

// File: tb/tb_triangular_root.sv
// tb_triangular_root: scoreboard bench for triangular_root.
// Each run pushes the expected result when its start is driven.
// The result is popped and compared when done rises.
module tb_triangular_root;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [W-1:0] target, n, rem;
    logic         exact, busy, done;

    triangular_root #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .target(target),
        .n(n), .rem(rem), .exact(exact), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int rem;
        int exact;
        int lat;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_tot++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, want);
    endtask

    // Reference model: the largest k whose triangular number fits in t.
    function automatic exp_t model(input int t);
        exp_t e;
        int   k;
        k = 0;
        for (int j = 0; j < 256; j++) if (j * (j + 1) / 2 <= t) k = j;
        e.n     = k;
        e.rem   = t - k * (k + 1) / 2;
        e.exact = (e.rem == 0) ? 1 : 0;
`ifdef TRIROOT_FAST_EN
        e.lat   = 2 * k + 1;
`else
        e.lat   = 3 * k + 1;
`endif
        return e;
    endfunction

    // Drives start/target just after an edge, so the next edge is the accept edge (edge 0).
    // pulse_at > 0: pulse start with target=200 at that edge; this should be ignored.
    // rst_at   > 0: assert reset at that edge and check the block is cleared.
    task automatic run(input int t, input int pulse_at, input int rst_at);
        exp_t e;
        int   cyc, busyc;
        bit   got;
        q.push_back(model(t));
        start  = 1'b1;
        target = W'(t);
        @(posedge clk); #1;
        start  = 1'b0;
        target = W'($urandom);
        cyc = 0; busyc = 0; got = 1'b0;
        while (cyc < 1000) begin
            chk("busy_done_excl", int'(busy & done), 0);
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busyc++;
            if (rst_at > 0 && cyc == rst_at - 1) reset = 1'b0;
            if (pulse_at > 0 && cyc == pulse_at - 1) begin
                start  = 1'b1;
                target = 8'd200;
            end
            @(posedge clk); #1;
            cyc++;
            if (pulse_at > 0 && cyc == pulse_at) start = 1'b0;
            if (rst_at > 0 && cyc == rst_at) begin
                chk("abort_n", int'(n), 0);
                chk("abort_rem", int'(rem), 0);
                chk("abort_busy", int'(busy), 0);
                chk("abort_done", int'(done), 0);
                chk("abort_exact", int'(exact), 0);
                reset = 1'b1;
                void'(q.pop_front());
                return;
            end
        end
        e = q.pop_front();
        if (!got) begin
            chk($sformatf("timeout_T%0d", t), 0, 1);
        end else begin
            chk($sformatf("n_T%0d", t), int'(n), e.n);
            chk($sformatf("rem_T%0d", t), int'(rem), e.rem);
            chk($sformatf("exact_T%0d", t), int'(exact), e.exact);
            chk($sformatf("lat_T%0d", t), cyc, e.lat);
            chk($sformatf("busycyc_T%0d", t), busyc, e.lat);
        end
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        target = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_n", int'(n), 0);
        chk("rst_rem", int'(rem), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_exact", int'(exact), 0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", int'(busy), 0);
        chk("idle_done", int'(done), 0);

        run(55, 0, 0);
        run(60, 0, 0);
        run(0, 0, 0);      // back-to-back from DONE
        run(255, 0, 0);
        run(1, 0, 0);
        run(10, 4, 0);     // start while busy is ignored
        run(100, 0, 7);    // reset mid-computation
        run(3, 0, 0);
        for (int k = 0; k < 6; k++) run(int'($urandom_range(0, 255)), 0, 0);

        // DONE holds its result with start low.
        repeat (4) @(posedge clk);
        #1;
        chk("hold_done", int'(done), 1);
        chk("hold_n", int'(n), model(target_last()).n);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    // Tracks the target of the most recent accepted run, for the hold check.
    int last_t = 0;
    always @(posedge clk) if (start && (done || !busy) && reset) last_t <= int'(target);
    function automatic int target_last();
        return last_t;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
